// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for a dual-pointer FIFO: owns the write pointer and derives
// occupancy, full/almost-full and a sticky overflow flag against the read pointer.
module fifo_wr_ctrl #(
    parameter int unsigned W_DATA_WIDTH = 16,
    parameter int unsigned MEM_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned AFULL_LEVEL  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_request,
    input  logic                  flush,
    input  logic                  ovf_clear,
    input  logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH:0]   wr_ptr,
    output logic                  wr_en,
    output logic                  full_flag,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  overflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned STEP  = W_DATA_WIDTH / MEM_WIDTH;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             ovf_event;

    // Status is combinational so a falling-edge read frees space within the same cycle.
    always_comb begin
        occupancy   = PTR_W'(wr_ptr_q - rd_ptr);
        full_flag   = occupancy > PTR_W'(FIFO_DEPTH - STEP);
        almost_full = occupancy >= PTR_W'(AFULL_LEVEL);
        // Gated by reset so an in-flight write is aborted while reset is held.
        wr_en       = reset & wr_request & ~full_flag & ~flush;
        ovf_event   = wr_request & full_flag & ~flush;
    end

    // Next-state: flush realigns to the reader and beats any write.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = rd_ptr;
        end else if (wr_en) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(STEP));
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (ovf_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_ptr   = wr_ptr_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a 1:1 instance driven against a small pointer model
// with a scoreboard queue, plus a 2:1 width instance for the STEP=2 full threshold.
module tb_fifo_wr_ctrl;

    localparam int unsigned PW = 5;

    typedef struct packed {
        logic [PW-1:0] ptr;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;

    logic          wr_request, flush, ovf_clear;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr, occupancy;
    logic          wr_en, full_flag, almost_full, overflow;

    logic          wr_request2, flush2, ovf_clear2;
    logic [PW-1:0] rd_ptr2;
    logic [PW-1:0] wr_ptr2, occupancy2;
    logic          wr_en2, full_flag2, almost_full2, overflow2;

    int            n_cmp = 0;
    int            n_err = 0;
    exp_t          exp_q[$];
    logic [PW-1:0] m_ptr;
    logic          m_ovf;

    always #5 clk = ~clk;

    fifo_wr_ctrl dut (
        .clk(clk), .reset(reset), .wr_request(wr_request), .flush(flush),
        .ovf_clear(ovf_clear), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .wr_en(wr_en),
        .full_flag(full_flag), .almost_full(almost_full), .occupancy(occupancy),
        .overflow(overflow)
    );

    fifo_wr_ctrl #(.W_DATA_WIDTH(32), .MEM_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset), .wr_request(wr_request2), .flush(flush2),
        .ovf_clear(ovf_clear2), .rd_ptr(rd_ptr2), .wr_ptr(wr_ptr2), .wr_en(wr_en2),
        .full_flag(full_flag2), .almost_full(almost_full2), .occupancy(occupancy2),
        .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the 1:1 instance: model the outcome, check status, then score the edge.
    task automatic cyc(input logic req, input logic fl, input logic clr);
        logic [PW-1:0] occ;
        logic          full, en;
        exp_t          e;
        wr_request = req;
        flush      = fl;
        ovf_clear  = clr;
        #1;
        occ  = PW'(m_ptr - rd_ptr);
        full = occ > 5'd15;
        en   = req & ~full & ~fl;
        check("occupancy", 32'(occupancy), 32'(occ));
        check("full_flag", 32'(full_flag), 32'(full));
        check("almost_full", 32'(almost_full), 32'(occ >= 5'd12));
        check("wr_en", 32'(wr_en), 32'(en));
        e.ptr = fl ? rd_ptr : (en ? PW'(m_ptr + 5'd1) : m_ptr);
        e.ovf = (req & full & ~fl) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        exp_q.push_back(e);
        tick();
        e = exp_q.pop_front();
        check("wr_ptr", 32'(wr_ptr), 32'(e.ptr));
        check("overflow", 32'(overflow), 32'(e.ovf));
        m_ptr = e.ptr;
        m_ovf = e.ovf;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e2;
        reset       = 1'b0;
        wr_request  = 1'b1;
        flush       = 1'b0;
        ovf_clear   = 1'b0;
        rd_ptr      = '0;
        wr_request2 = 1'b0;
        flush2      = 1'b0;
        ovf_clear2  = 1'b0;
        rd_ptr2     = '0;
        m_ptr       = '0;
        m_ovf       = 1'b0;

        #2;
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_full", 32'(full_flag), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_wr_ptr2", 32'(wr_ptr2), 32'd0);
        tick();
        tick();
        wr_request = 1'b0;
        reset      = 1'b1;

        // Fill from empty to full.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0);
        check("fill_wr_ptr", 32'(wr_ptr), 32'd16);
        check("fill_full", 32'(full_flag), 32'd1);
        check("fill_occupancy", 32'(occupancy), 32'd16);

        // Writes while full: pointer holds, overflow sticks, clear and set-wins.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("ovf_hold_ptr", 32'(wr_ptr), 32'd16);
        check("ovf_set", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        check("ovf_clear", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b1);

        // Falling-edge read frees space for a write on the following rising edge.
        @(negedge clk);
        rd_ptr = 5'd1;
        cyc(1'b1, 1'b0, 1'b0);
        check("read_write_ptr", 32'(wr_ptr), 32'd17);
        check("read_write_full", 32'(full_flag), 32'd1);

        // Wrap through the extra MSB.
        @(negedge clk);
        rd_ptr = 5'd30;
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        check("wrap_ptr", 32'(wr_ptr), 32'd2);
        check("wrap_occupancy", 32'(occupancy), 32'd4);

        // Flush with a concurrent request at occupancy 9.
        rd_ptr = 5'd5;
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0);
        check("pre_flush_occ", 32'(occupancy), 32'd9);
        cyc(1'b1, 1'b1, 1'b0);
        check("flush_ptr", 32'(wr_ptr), 32'd5);
        check("flush_occupancy", 32'(occupancy), 32'd0);

        // Overflow, then asynchronous reset mid-cycle clears state without a clock.
        rd_ptr = 5'd21;
        cyc(1'b1, 1'b0, 1'b0);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_ptr", 32'(wr_ptr), 32'd0);
        check("async_rst_ovf", 32'(overflow), 32'd0);
        rd_ptr = '0;
        #1;
        check("async_rst_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_ptr = '0;
        m_ovf = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        check("post_rst_ptr", 32'(wr_ptr), 32'd1);
        wr_request = 1'b0;

        // 32-bit words into 16-bit entries: pointer steps by two.
        for (int i = 0; i < 8; i++) begin
            wr_request2 = 1'b1;
            #1;
            check("w2_wr_en", 32'(wr_en2), 32'd1);
            e2.ptr = PW'(2 * (i + 1));
            e2.ovf = 1'b0;
            exp_q.push_back(e2);
            tick();
            e2 = exp_q.pop_front();
            check("w2_wr_ptr", 32'(wr_ptr2), 32'(e2.ptr));
        end
        check("w2_full16", 32'(full_flag2), 32'd1);
        check("w2_wr_en_full", 32'(wr_en2), 32'd0);
        @(negedge clk);
        rd_ptr2 = 5'd1;
        #1;
        check("w2_occ15", 32'(occupancy2), 32'd15);
        check("w2_full15", 32'(full_flag2), 32'd1);
        check("w2_wr_en15", 32'(wr_en2), 32'd0);
        tick();
        check("w2_hold_ptr", 32'(wr_ptr2), 32'd16);
        check("w2_overflow", 32'(overflow2), 32'd1);
        @(negedge clk);
        rd_ptr2 = 5'd2;
        #1;
        check("w2_occ14", 32'(occupancy2), 32'd14);
        check("w2_full14", 32'(full_flag2), 32'd0);
        check("w2_wr_en14", 32'(wr_en2), 32'd1);
        tick();
        check("w2_step_ptr", 32'(wr_ptr2), 32'd18);
        check("w2_refull", 32'(full_flag2), 32'd1);
        wr_request2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
